// File: rtl/clock_generation_sim.sv
// Reset-controlled divided clock for simulation benches.
// One output clock with programmable start-up delay and phase.
module clock_generation_sim #(
  parameter longint unsigned REF_CLK_FREQUENCY        = 64'd1_000_000_000,
  parameter longint unsigned CLK_1_FREQUENCY          = 64'd100_000_000,
  parameter longint unsigned CLK_1_INITIALIZING_DELAY = 64'd0,
  parameter longint unsigned CLK_1_PHASE              = 64'd0
) (
  input  logic clk,
  input  logic rstb,
  output logic clk_out_1,
  output logic clk_out_1_valid
);
  timeunit 1ns;
  timeprecision 100ps;

  // Safe divisor so the constant math never divides by zero
  localparam longint unsigned F1S =
    (CLK_1_FREQUENCY == 64'd0) ? 64'd1 : CLK_1_FREQUENCY;
  localparam longint unsigned N   = REF_CLK_FREQUENCY / F1S;
  localparam longint unsigned REM = REF_CLK_FREQUENCY % F1S;
  localparam longint unsigned H   = N / 64'd2;
  localparam longint unsigned D   =
    CLK_1_INITIALIZING_DELAY * (REF_CLK_FREQUENCY / 64'd1_000_000_000);
  localparam longint unsigned P   =
    ((CLK_1_PHASE % 64'd360) * N) / 64'd360;
  localparam longint unsigned DP  = D + P;
  localparam logic [31:0]     H32 = H[31:0];

  if (CLK_1_FREQUENCY == 64'd0) begin : g_err_zero
    $fatal(1, "clock_generation_sim: CLK_1_FREQUENCY is 0");
  end else if (REM != 64'd0) begin : g_err_ratio
    $fatal(1, "clock_generation_sim: REF not a multiple of CLK_1");
  end else if (N < 64'd2 || N[0]) begin : g_err_odd
    $fatal(1, "clock_generation_sim: divide ratio odd or < 2");
  end

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic        clk_q, clk_d;
  logic        vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    clk_d   = clk_q;
    vld_d   = vld_q;
    unique case (state_q)
      S_WAIT: begin
        if (64'(dcnt_q) == DP) begin
          state_d = S_RUN;
          clk_d   = 1'b1;
          vld_d   = 1'b1;
          hcnt_d  = 32'd1;
        end else if (dcnt_q != '1) begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (hcnt_q == H32) begin
          clk_d  = ~clk_q;
          hcnt_d = 32'd1;
        end else begin
          hcnt_d = hcnt_q + 32'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_WAIT;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      clk_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      clk_q   <= clk_d;
      vld_q   <= vld_d;
    end
  end

  assign clk_out_1       = clk_q;
  assign clk_out_1_valid = vld_q;

endmodule

// File: tb/tb_clock_generation_sim.sv
// Bench for clock_generation_sim: several parameter sets share clk/rstb,
// expected waveforms queued per edge and checked by a monitor.
module tb_clock_generation_sim;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int ND = 7;
  localparam longint unsigned REF_A[ND] = '{
    64'd1_000_000_000, 64'd1_000_000_000, 64'd1_000_000_000,
    64'd1_000_000_000, 64'd1_000_000_000, 64'd1_000_000_000,
    64'd2_000_000_000};
  localparam longint unsigned F1_A[ND] = '{
    64'd100_000_000, 64'd100_000_000, 64'd100_000_000,
    64'd100_000_000, 64'd100_000_000, 64'd500_000_000,
    64'd250_000_000};
  localparam longint unsigned DLY_A[ND] = '{
    64'd0, 64'd20, 64'd0, 64'd0, 64'd7, 64'd0, 64'd3};
  localparam longint unsigned PH_A[ND] = '{
    64'd0, 64'd0, 64'd90, 64'd450, 64'd180, 64'd270, 64'd45};

  logic          clk;
  logic          rstb;
  logic [ND-1:0] co;
  logic [ND-1:0] cv;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    clock_generation_sim #(
      .REF_CLK_FREQUENCY       (REF_A[g]),
      .CLK_1_FREQUENCY         (F1_A[g]),
      .CLK_1_INITIALIZING_DELAY(DLY_A[g]),
      .CLK_1_PHASE             (PH_A[g])
    ) u_dut (
      .clk            (clk),
      .rstb           (rstb),
      .clk_out_1      (co[g]),
      .clk_out_1_valid(cv[g])
    );
  end

  initial clk = 1'b0;
  always #0.5 clk = ~clk;

  typedef struct {
    int            k;
    logic [ND-1:0] c;
    logic [ND-1:0] v;
  } exp_t;

  exp_t q[$];
  int   nchk;
  int   npass;

  // Start edge of the first rise, from the delay and phase rules
  function automatic longint start_of(int i);
    longint n;
    n = longint'(REF_A[i] / F1_A[i]);
    return longint'(DLY_A[i] * (REF_A[i] / 64'd1_000_000_000))
         + longint'(((PH_A[i] % 64'd360) * 64'(n)) / 64'd360);
  endfunction

  function automatic longint half_of(int i);
    return longint'(REF_A[i] / F1_A[i]) / 2;
  endfunction

  // k = edges since reset release (0 while in reset)
  function automatic exp_t model(int k);
    exp_t   e;
    longint s;
    longint h;
    e.k = k;
    e.c = '0;
    e.v = '0;
    for (int i = 0; i < ND; i++) begin
      s = start_of(i);
      h = half_of(i);
      if (k > 0 && longint'(k) >= s + 1) begin
        e.v[i] = 1'b1;
        e.c[i] = (((longint'(k) - s - 1) / h) % 2) == 0;
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, int i, int k, logic act, logic exp);
    nchk++;
    if (act === exp) npass++;
    else
      $display("FAIL %s dut%0d edge%0d got=%0b want=%0b",
               nm, i, k, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < ND; i++) begin
        chk("clk_out_1", i, e.k, co[i], e.c[i]);
        chk("valid", i, e.k, cv[i], e.v[i]);
      end
    end
  end

  task automatic step(logic r, int k);
    @(negedge clk);
    rstb = r;
    @(posedge clk);
    q.push_back(model(k));
  endtask

  task automatic async_reset(int k);
    @(negedge clk);
    #0.2;
    rstb = 1'b0;
    #0.1;
    for (int i = 0; i < ND; i++) begin
      chk("async_clk", i, k, co[i], 1'b0);
      chk("async_valid", i, k, cv[i], 1'b0);
    end
  endtask

  task automatic run(int nrst, int len);
    for (int j = 0; j < nrst; j++) step(1'b0, 0);
    for (int k = 1; k <= len; k++) step(1'b1, k);
    async_reset(len);
  endtask

  initial begin
    nchk  = 0;
    npass = 0;
    rstb  = 1'b0;
    #0.2;
    for (int i = 0; i < ND; i++) begin
      chk("rst_clk", i, 0, co[i], 1'b0);
      chk("rst_valid", i, 0, cv[i], 1'b0);
    end
    // Default clock is high at edge 23, so this reset hits a high phase
    run(10, 23);
    run(2, 45);
    for (int t = 0; t < 6; t++)
      run(int'($urandom_range(1, 5)), int'($urandom_range(1, 60)));
    step(1'b0, 0);
    @(negedge clk);
    #0.2;
    nchk++;
    if (q.size() == 0) npass++;
    else $display("FAIL drain left=%0d want=0", q.size());
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_generation_sim.md
Name: clock_generation_sim

Overview:
- Parameterised clock generator for simulation benches.
- Derives one divided clock, clk_out_1, from a fast reference clock clk.
- clk_out_1 has a programmable start-up delay and phase offset; it replaces free-running behavioural clock loops so bench clocks are reset-controlled and cycle-deterministic.

Parameters:
- REF_CLK_FREQUENCY, 1_000_000_000, frequency of clk in Hz (1 ns reference period).
- CLK_1_FREQUENCY, 100_000_000, target frequency of clk_out_1 in Hz.
- CLK_1_INITIALIZING_DELAY, 0, start-up delay in ns before clk_out_1 begins toggling.
- CLK_1_PHASE, 0, phase offset of clk_out_1 in degrees; values >=360 are reduced modulo 360.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- rstb  input  1  asynchronous active-low reset.
- clk_out_1  output  1  generated clock.
- clk_out_1_valid  output  1  high once clk_out_1 is toggling at its programmed rate.

Behaviour:
Derived constants, all computed at elaboration with integer arithmetic:
- N = REF_CLK_FREQUENCY / CLK_1_FREQUENCY, the divide ratio.
- H = N/2, half-period in reference cycles.
- D = CLK_1_INITIALIZING_DELAY * (REF_CLK_FREQUENCY / 1_000_000_000), delay in reference cycles; use 64-bit intermediates.
- P = ((CLK_1_PHASE mod 360) * N) / 360, truncated.

Elaboration checks (fatal error):
- REF_CLK_FREQUENCY not an exact multiple of CLK_1_FREQUENCY.
- N odd, or N < 2.
- CLK_1_FREQUENCY = 0.

Internal counters:
- 32-bit counters.
- The delay counter saturates; it never wraps.

Reset (rstb low, asynchronous):
- clk_out_1 = 0, clk_out_1_valid = 0.
- All counters cleared; FSM in WAIT.
- Reset asserted mid-operation clears outputs immediately, without waiting for a clk edge.
- After release the full D+P delay is re-applied.

FSM states: WAIT, RUN.
- Edge numbering: edge 1 is the first rising edge of clk at which rstb is sampled high.
- WAIT:
  - clk_out_1 held 0; delay counter increments each edge.
  - When the count reaches D+P, the next edge moves to RUN.
  - Net effect: clk_out_1 and clk_out_1_valid both rise at edge D+P+1.
  - If D+P = 0, they rise at edge 1.
- RUN:
  - Half-period counter counts 1..H.
  - clk_out_1 toggles each time the counter hits H, then the counter resets to 1.
  - Rising edges at D+P+1+2kH; falling edges at D+P+1+(2k+1)H.
  - clk_out_1_valid stays 1 until reset.
- Duty cycle is exactly 50 %.
- Outputs are registered; there are no combinational paths from rstb or clk to the outputs other than the async clear.

Test Plan:
- Defaults (N=10, H=5, D=0, P=0), 1 ns clk, rstb released after 10 ns -> clk_out_1 rises at edge 1 after release, period 10 ns, high 5 ns / low 5 ns; clk_out_1_valid rises at the same edge.
- CLK_1_INITIALIZING_DELAY=20, CLK_1_PHASE=0 -> first clk_out_1 rise at edge 21, then period 10 ns; both outputs 0 for edges 1..20.
- CLK_1_PHASE=90, N=10 -> P=2, first rise at edge 3; CLK_1_PHASE=450 -> identical waveform.
- Combined: CLK_1_INITIALIZING_DELAY=7, CLK_1_PHASE=180 -> first rise at edge 13, fall at edge 18, next rise at edge 23.
- Reset mid-run: pull rstb low while clk_out_1 = 1 -> both outputs drop to 0 immediately; on release the delay is restarted and the first rise occurs at edge D+P+1 again.
- Illegal parameters CLK_1_FREQUENCY=300_000_000 (non-integer ratio) or 500_000_000 with REF=1.5 GHz (odd N=3) -> elaboration fails with an error message.
